// File: rtl/mem_io_sink.sv
// Snoops the CPU memory-write monitor port, queues in-window writes as {addr, data}
// records in a show-ahead FIFO, and flags/counts any record dropped because the FIFO was full.
module mem_io_sink #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [7:0]  IO_BASE  = 8'hF0,
    parameter logic [7:0]  IO_LIMIT = 8'hFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     MemRW_IO,
    input  logic [7:0]               MemAddr_IO,
    input  logic [15:0]              MemD_IO,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_addr,
    output logic [15:0]              out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    input  logic                     clr_ovf
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } rec_t;

    rec_t             mem_q [DEPTH];
    rec_t             wr_rec;
    rec_t             head_q, head_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic             hit, push, pop, drop;

    // Capture decision and FIFO pointer/occupancy update.
    always_comb begin
        wr_rec      = '{addr: MemAddr_IO, data: MemD_IO};
        hit         = MemRW_IO && (MemAddr_IO >= IO_BASE) && (MemAddr_IO <= IO_LIMIT);
        pop         = out_valid_q && out_ready;
        push        = hit && ((count_q != CNT_W'(DEPTH)) || pop);
        drop        = hit && !push;

        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (push && !pop)      count_d = count_q + CNT_W'(1);
        else if (pop && !push) count_d = count_q - CNT_W'(1);

        // Head register tracks the post-edge read slot; bypass when that slot is being written now.
        out_valid_d = (count_d != '0);
        head_d      = '0;
        if (out_valid_d) begin
            if (push && (wr_ptr_q == rd_ptr_d)) head_d = wr_rec;
            else                                head_d = mem_q[rd_ptr_d];
        end
    end

    // Sticky overflow flag and saturating drop counter; a drop beats a same-cycle clear.
    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clr_ovf)                 drop_cnt_d = 8'd1;
            else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            head_q      <= '0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= 8'd0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            head_q      <= head_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Record storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_rec;
    end

    assign out_valid = out_valid_q;
    assign out_addr  = head_q.addr;
    assign out_data  = head_q.data;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_mem_io_sink.sv
// Directed bench for mem_io_sink: vector table for the address filter, hand sequences
// for fill/overflow, pop-while-full, clear race, saturation and asynchronous reset.
module tb_mem_io_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemRW_IO;
    logic [7:0]  MemAddr_IO;
    logic [15:0] MemD_IO;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_addr;
    logic [15:0] out_data;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        clr_ovf;

    int n_pass  = 0;
    int n_total = 0;

    mem_io_sink #(.DEPTH(8), .IO_BASE(8'hF0), .IO_LIMIT(8'hFF)) dut (
        .clk(clk), .rst(rst),
        .MemRW_IO(MemRW_IO), .MemAddr_IO(MemAddr_IO), .MemD_IO(MemD_IO),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data),
        .count(count), .overflow(overflow), .drop_cnt(drop_cnt),
        .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rw;
        logic [7:0]  addr;
        logic [15:0] data;
        logic        rdy;
        logic        e_valid;
        logic [7:0]  e_addr;
        logic [15:0] e_data;
        int          e_count;
    } vec_t;

    function automatic vec_t mk(logic rw, logic [7:0] a, logic [15:0] d, logic rdy,
                                logic ev, logic [7:0] ea, logic [15:0] ed, int ec);
        vec_t v;
        v.rw = rw; v.addr = a; v.data = d; v.rdy = rdy;
        v.e_valid = ev; v.e_addr = ea; v.e_data = ed; v.e_count = ec;
        return v;
    endfunction

    task automatic chk(string name, int unsigned act, int unsigned exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic rw, logic [7:0] a, logic [15:0] d, logic rdy, logic clr);
        MemRW_IO = rw; MemAddr_IO = a; MemD_IO = d; out_ready = rdy; clr_ovf = clr;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, " valid"},    out_valid, 0);
        chk({tag, " count"},    count, 0);
        chk({tag, " addr"},     out_addr, 0);
        chk({tag, " data"},     out_data, 0);
        chk({tag, " overflow"}, overflow, 0);
        chk({tag, " drop_cnt"}, drop_cnt, 0);
    endtask

    vec_t vecs[8];
    logic [15:0] drain_exp[8];

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'h00, 16'h0, 1'b0, 1'b0);
        step(); step();
        chk_zero("reset");
        rst = 1'b0;

        // Address filter: only F0 and FF pass; MemRW_IO=0 at F5 ignored; ready on empty ignored.
        vecs[0] = mk(1, 8'hEF, 16'd1, 0, 0, 8'h00, 16'h0, 0);
        vecs[1] = mk(1, 8'hF0, 16'd2, 0, 1, 8'hF0, 16'd2, 1);
        vecs[2] = mk(1, 8'hFF, 16'd3, 0, 1, 8'hF0, 16'd2, 2);
        vecs[3] = mk(1, 8'h10, 16'd4, 0, 1, 8'hF0, 16'd2, 2);
        vecs[4] = mk(0, 8'hF5, 16'd5, 0, 1, 8'hF0, 16'd2, 2);
        vecs[5] = mk(0, 8'h00, 16'd0, 1, 1, 8'hFF, 16'd3, 1);
        vecs[6] = mk(0, 8'h00, 16'd0, 1, 0, 8'h00, 16'h0, 0);
        vecs[7] = mk(0, 8'h00, 16'd0, 1, 0, 8'h00, 16'h0, 0);
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].rw, vecs[i].addr, vecs[i].data, vecs[i].rdy, 1'b0);
            step();
            chk($sformatf("vec%0d valid", i), out_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d count", i), count, vecs[i].e_count);
            chk($sformatf("vec%0d overflow", i), overflow, 0);
            if (vecs[i].e_valid) begin
                chk($sformatf("vec%0d addr", i), out_addr, vecs[i].e_addr);
                chk($sformatf("vec%0d data", i), out_data, vecs[i].e_data);
            end
        end

        // Fill past full: 10 writes, last two dropped.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'hF1, 16'(i), 1'b0, 1'b0);
            step();
            chk($sformatf("fill%0d count", i), count, (i < 8) ? i + 1 : 8);
            chk($sformatf("fill%0d drop_cnt", i), drop_cnt, (i < 8) ? 0 : i - 7);
            chk($sformatf("fill%0d overflow", i), overflow, (i < 8) ? 0 : 1);
        end
        chk("full head data", out_data, 16'd0);

        // Pop while full: the write is accepted, occupancy unchanged.
        drive(1'b1, 8'hF1, 16'hBEEF, 1'b1, 1'b0);
        step();
        chk("pwf count", count, 8);
        chk("pwf drop_cnt", drop_cnt, 2);
        chk("pwf head data", out_data, 16'd1);
        MemRW_IO = 1'b0;
        for (int k = 0; k < 7; k++) drain_exp[k] = 16'(k + 1);
        drain_exp[7] = 16'hBEEF;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("drain%0d valid", k), out_valid, 1);
            chk($sformatf("drain%0d addr", k), out_addr, 8'hF1);
            chk($sformatf("drain%0d data", k), out_data, drain_exp[k]);
            step();
        end
        chk("drained valid", out_valid, 0);
        chk("drained count", count, 0);

        // Clear race: build drop_cnt to 5, clear alone, then clear during a drop.
        for (int i = 0; i < 11; i++) begin
            drive(1'b1, 8'hF3, 16'(100 + i), 1'b0, 1'b0);
            step();
        end
        chk("five drop_cnt", drop_cnt, 5);
        chk("five overflow", overflow, 1);
        drive(1'b0, 8'hF3, 16'h0, 1'b0, 1'b1);
        step();
        chk("clr drop_cnt", drop_cnt, 0);
        chk("clr overflow", overflow, 0);
        drive(1'b1, 8'hF3, 16'h0, 1'b0, 1'b1);
        step();
        chk("race drop_cnt", drop_cnt, 1);
        chk("race overflow", overflow, 1);
        chk("race count", count, 8);
        // Full FIFO plus out-of-window strobe: no drop.
        drive(1'b1, 8'h20, 16'h0, 1'b0, 1'b0);
        step();
        chk("oow drop_cnt", drop_cnt, 1);
        drive(1'b1, 8'hF3, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) step();
        chk("sat drop_cnt", drop_cnt, 255);
        chk("sat count", count, 8);

        // Asynchronous reset mid-cycle clears outputs before the next edge.
        MemRW_IO = 1'b0;
        #2 rst = 1'b1;
        #1 chk_zero("async rst");
        step();
        rst = 1'b0;
        drive(1'b0, 8'h00, 16'h0, 1'b1, 1'b0);
        step();
        chk("idle ready valid", out_valid, 0);
        chk("idle ready count", count, 0);

        // Reset mid-stream discards queued records.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'hF4, 16'(7 + i), 1'b0, 1'b0);
            step();
        end
        chk("3q count", count, 3);
        MemRW_IO = 1'b0;
        #2 rst = 1'b1;
        #1 chk("midrst count", count, 0);
        chk("midrst valid", out_valid, 0);
        step();
        rst = 1'b0;
        drive(1'b1, 8'hF2, 16'h1234, 1'b0, 1'b0);
        step();
        chk("post valid", out_valid, 1);
        chk("post addr", out_addr, 8'hF2);
        chk("post data", out_data, 16'h1234);
        chk("post count", count, 1);
        drive(1'b0, 8'h00, 16'h0, 1'b1, 1'b0);
        step();
        chk("post drain valid", out_valid, 0);
        chk("post drain count", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
